// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand capture with x0 forcing and WB bypass,
// load-use bubble insertion, external stall (hold) and flush.
module id_ex_stage #(
    parameter int                 XLEN     = 32,
    parameter int                 CTRL_W   = 16,
    parameter logic [CTRL_W-1:0]  NOP_CTRL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [XLEN-1:0]   rf_rd1,
    input  logic [XLEN-1:0]   rf_rd2,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_wd,
    input  logic              stall_in,
    input  logic              flush_in,
    output logic              id_stall_req,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_rs1_val,
    output logic [XLEN-1:0]   ex_rs2_val,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_reg_write,
    output logic              ex_mem_read
);

    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            load_use;
    logic            hold_wb1;
    logic            hold_wb2;

    // The register file is written on the same edge it is read, so a
    // same-cycle write-back must be forwarded; x0 is not hardwired there.
    always_comb begin
        op1 = rf_rd1;
        if (id_rs1 == 5'd0)
            op1 = '0;
        else if (wb_we && (wb_rd == id_rs1))
            op1 = wb_wd;
    end

    always_comb begin
        op2 = rf_rd2;
        if (id_rs2 == 5'd0)
            op2 = '0;
        else if (wb_we && (wb_rd == id_rs2))
            op2 = wb_wd;
    end

    assign load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0)
                   && id_valid
                   && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    assign id_stall_req = !flush_in && (stall_in || load_use);

    // Keep held operands fresh while a write-back retires underneath them.
    assign hold_wb1 = wb_we && (wb_rd != 5'd0) && (wb_rd == ex_rs1);
    assign hold_wb2 = wb_we && (wb_rd != 5'd0) && (wb_rd == ex_rs2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_pc        <= '0;
            ex_imm       <= '0;
            ex_rs1_val   <= '0;
            ex_rs2_val   <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_ctrl      <= NOP_CTRL;
        end else if (flush_in) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_ctrl      <= NOP_CTRL;
            ex_pc        <= id_pc;
            ex_imm       <= id_imm;
            ex_rs1_val   <= op1;
            ex_rs2_val   <= op2;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rd        <= id_rd;
        end else if (stall_in) begin
            if (hold_wb1)
                ex_rs1_val <= wb_wd;
            if (hold_wb2)
                ex_rs2_val <= wb_wd;
        end else if (load_use) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_ctrl      <= NOP_CTRL;
        end else begin
            ex_valid     <= id_valid;
            ex_reg_write <= id_reg_write && id_valid;
            ex_mem_read  <= id_mem_read && id_valid;
            ex_ctrl      <= id_ctrl;
            ex_pc        <= id_pc;
            ex_imm       <= id_imm;
            ex_rs1_val   <= op1;
            ex_rs2_val   <= op2;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rd        <= id_rd;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for single-cycle loads plus
// hand sequences for reset, load-use bubble, stall refresh and flush.
module tb_id_ex_stage;

    localparam int          XLEN = 32;
    localparam int          CW   = 16;
    localparam logic [15:0] NOP  = 16'hA5A5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid;
    logic [31:0]     id_pc;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [31:0]     id_imm;
    logic [15:0]     id_ctrl;
    logic            id_reg_write;
    logic            id_mem_read;
    logic [31:0]     rf_rd1;
    logic [31:0]     rf_rd2;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [31:0]     wb_wd;
    logic            stall_in;
    logic            flush_in;
    logic            id_stall_req;
    logic            ex_valid;
    logic [31:0]     ex_pc;
    logic [31:0]     ex_imm;
    logic [31:0]     ex_rs1_val;
    logic [31:0]     ex_rs2_val;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic [15:0]     ex_ctrl;
    logic            ex_reg_write;
    logic            ex_mem_read;

    int n_chk = 0;
    int n_fail = 0;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CW), .NOP_CTRL(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd), .stall_in(stall_in),
        .flush_in(flush_in), .id_stall_req(id_stall_req),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_ctrl(ex_ctrl), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic [31:0] rf1;
        logic [31:0] rf2;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [15:0] ctrl;
        logic        e_stall;
        logic        e_valid;
        logic        e_rw;
        logic        e_mr;
        logic [31:0] e_v1;
        logic [31:0] e_v2;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc,
                          input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic [31:0] imm,
                          input logic [15:0] c, input logic rw,
                          input logic mr);
        id_valid = v; id_pc = pc; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_imm = imm; id_ctrl = c; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic set_rf(input logic [31:0] a, input logic [31:0] b);
        rf_rd1 = a; rf_rd2 = b;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd,
                          input logic [31:0] wd);
        wb_we = we; wb_rd = rd; wb_wd = wd;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " valid"}, 64'(ex_valid), 64'd0);
        chk({tag, " rw"}, 64'(ex_reg_write), 64'd0);
        chk({tag, " mr"}, 64'(ex_mem_read), 64'd0);
        chk({tag, " ctrl"}, 64'(ex_ctrl), 64'(NOP));
        chk({tag, " pc"}, 64'(ex_pc), 64'd0);
        chk({tag, " imm"}, 64'(ex_imm), 64'd0);
        chk({tag, " v1"}, 64'(ex_rs1_val), 64'd0);
        chk({tag, " v2"}, 64'(ex_rs2_val), 64'd0);
        chk({tag, " idx"}, 64'({ex_rs1, ex_rs2, ex_rd}), 64'd0);
    endtask

    initial begin
        // valid rs1 rs2 rd rw mr rf1 rf2 we wrd wd pc imm ctrl
        //   | e_stall e_valid e_rw e_mr e_v1 e_v2
        vt[0] = '{1, 0, 3, 1, 1, 0, 32'hDEADBEEF, 32'h33, 0, 0, 0,
                  32'h10, 32'h1, 16'h0101, 0, 1, 1, 0, 32'h0, 32'h33};
        vt[1] = '{1, 4, 5, 2, 1, 0, 32'h44, 32'h11, 1, 5, 32'h22,
                  32'h14, 32'h2, 16'h0202, 0, 1, 1, 0, 32'h44, 32'h22};
        vt[2] = '{1, 4, 5, 2, 0, 0, 32'h44, 32'h11, 1, 0, 32'h22,
                  32'h18, 32'h3, 16'h0303, 0, 1, 0, 0, 32'h44, 32'h11};
        vt[3] = '{1, 6, 0, 3, 1, 0, 32'h66, 32'h55, 1, 0, 32'h99,
                  32'h1C, 32'h4, 16'h0404, 0, 1, 1, 0, 32'h66, 32'h0};
        vt[4] = '{0, 1, 2, 4, 1, 1, 32'h1, 32'h2, 0, 1, 32'h7,
                  32'h20, 32'h5, 16'h0505, 0, 0, 0, 0, 32'h1, 32'h2};
        vt[5] = '{1, 1, 2, 0, 1, 1, 32'hA1, 32'hA2, 1, 1, 32'hB1,
                  32'h24, 32'h6, 16'h0606, 0, 1, 1, 1, 32'hB1, 32'hA2};
        vt[6] = '{1, 0, 0, 6, 1, 0, 32'hC1, 32'hC2, 0, 0, 0,
                  32'h28, 32'h7, 16'h0707, 0, 1, 1, 0, 32'h0, 32'h0};
        vt[7] = '{1, 1, 2, 8, 1, 1, 32'hD1, 32'hD2, 0, 0, 0,
                  32'h2C, 32'h8, 16'h0808, 0, 1, 1, 1, 32'hD1, 32'hD2};
        vt[8] = '{0, 8, 8, 9, 1, 0, 32'hE1, 32'hE2, 1, 2, 32'hF,
                  32'h30, 32'h9, 16'h0909, 0, 0, 0, 0, 32'hE1, 32'hE2};

        rst_n = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
        set_id(1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
               $urandom, 16'($urandom), 1, 1);
        set_rf($urandom, $urandom);
        set_wb(1, 5'($urandom), $urandom);
        step();
        step();
        chk_reset("reset");
        rst_n = 1'b1;
        set_wb(0, 0, 0);

        for (int i = 0; i < 9; i++) begin
            set_id(vt[i].valid, vt[i].pc, vt[i].rs1, vt[i].rs2, vt[i].rd,
                   vt[i].imm, vt[i].ctrl, vt[i].rw, vt[i].mr);
            set_rf(vt[i].rf1, vt[i].rf2);
            set_wb(vt[i].we, vt[i].wrd, vt[i].wd);
            #1;
            chk($sformatf("v%0d stall", i), 64'(id_stall_req),
                64'(vt[i].e_stall));
            step();
            chk($sformatf("v%0d valid", i), 64'(ex_valid),
                64'(vt[i].e_valid));
            chk($sformatf("v%0d rw", i), 64'(ex_reg_write), 64'(vt[i].e_rw));
            chk($sformatf("v%0d mr", i), 64'(ex_mem_read), 64'(vt[i].e_mr));
            chk($sformatf("v%0d v1", i), 64'(ex_rs1_val), 64'(vt[i].e_v1));
            chk($sformatf("v%0d v2", i), 64'(ex_rs2_val), 64'(vt[i].e_v2));
            chk($sformatf("v%0d pc", i), 64'(ex_pc), 64'(vt[i].pc));
            chk($sformatf("v%0d imm", i), 64'(ex_imm), 64'(vt[i].imm));
            chk($sformatf("v%0d ctrl", i), 64'(ex_ctrl), 64'(vt[i].ctrl));
            chk($sformatf("v%0d idx", i), 64'({ex_rs1, ex_rs2, ex_rd}),
                64'({vt[i].rs1, vt[i].rs2, vt[i].rd}));
        end

        // Load-use: load rd=7 in EX, consumer rs1=7 in decode.
        set_wb(0, 0, 0);
        set_id(1, 32'h40, 1, 2, 7, 32'h0, 16'h1111, 1, 1);
        set_rf(32'h1, 32'h2);
        step();
        set_id(1, 32'h44, 7, 3, 10, 32'h4, 16'h2222, 1, 0);
        set_rf(32'h1111, 32'h33);
        #1;
        chk("lu stall_req", 64'(id_stall_req), 64'd1);
        step();
        chk("lu bubble valid", 64'(ex_valid), 64'd0);
        chk("lu bubble rw", 64'(ex_reg_write), 64'd0);
        chk("lu bubble mr", 64'(ex_mem_read), 64'd0);
        chk("lu bubble ctrl", 64'(ex_ctrl), 64'(NOP));
        chk("lu stall_req clr", 64'(id_stall_req), 64'd0);
        set_wb(1, 7, 32'hABCD0123);
        step();
        chk("lu cons valid", 64'(ex_valid), 64'd1);
        chk("lu cons v1", 64'(ex_rs1_val), 64'hABCD0123);
        chk("lu cons pc", 64'(ex_pc), 64'h44);
        chk("lu cons v2", 64'(ex_rs2_val), 64'h33);

        // Hold refresh: ex_rs2=9 holding 5 across a 3-cycle stall.
        set_wb(0, 0, 0);
        set_id(1, 32'h100, 2, 9, 11, 32'h50, 16'h3333, 1, 0);
        set_rf(32'h66, 32'h5);
        step();
        chk("hr load v2", 64'(ex_rs2_val), 64'h5);
        stall_in = 1'b1;
        set_id(1, 32'h200, 12, 13, 14, 32'h60, 16'h4444, 0, 1);
        set_rf(32'hEE, 32'hFF);
        #1;
        chk("hr stall_req", 64'(id_stall_req), 64'd1);
        step();
        chk("hr c1 v2", 64'(ex_rs2_val), 64'h5);
        chk("hr c1 pc", 64'(ex_pc), 64'h100);
        set_wb(1, 9, 32'h77);
        step();
        chk("hr c2 v2", 64'(ex_rs2_val), 64'h77);
        chk("hr c2 v1", 64'(ex_rs1_val), 64'h66);
        chk("hr c2 pc", 64'(ex_pc), 64'h100);
        chk("hr c2 imm", 64'(ex_imm), 64'h50);
        chk("hr c2 ctrl", 64'(ex_ctrl), 64'h3333);
        chk("hr c2 flags", 64'({ex_valid, ex_reg_write, ex_mem_read}),
            64'b110);
        chk("hr c2 idx", 64'({ex_rs1, ex_rs2, ex_rd}),
            64'({5'd2, 5'd9, 5'd11}));
        set_wb(0, 0, 0);
        step();
        chk("hr c3 v2", 64'(ex_rs2_val), 64'h77);
        stall_in = 1'b0;

        // Flush beats stall and load-use.
        set_id(1, 32'h300, 1, 2, 7, 32'h0, 16'h5555, 1, 1);
        step();
        set_id(1, 32'h304, 7, 7, 15, 32'h8, 16'h6666, 1, 1);
        #1;
        chk("fl pre lu", 64'(id_stall_req), 64'd1);
        stall_in = 1'b1;
        flush_in = 1'b1;
        #1;
        chk("fl stall_req", 64'(id_stall_req), 64'd0);
        step();
        chk("fl valid", 64'(ex_valid), 64'd0);
        chk("fl rw", 64'(ex_reg_write), 64'd0);
        chk("fl mr", 64'(ex_mem_read), 64'd0);
        chk("fl ctrl", 64'(ex_ctrl), 64'(NOP));
        chk("fl pc", 64'(ex_pc), 64'h304);
        stall_in = 1'b0;
        flush_in = 1'b0;

        // Reset while stalled.
        set_id(1, 32'h400, 3, 4, 5, 32'h9, 16'h7777, 1, 0);
        set_rf(32'h31, 32'h41);
        step();
        chk("rs pre valid", 64'(ex_valid), 64'd1);
        stall_in = 1'b1;
        rst_n = 1'b0;
        step();
        chk_reset("rs mid");
        rst_n = 1'b1;
        stall_in = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
